// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage and its buffer.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES      = 4;
  // Dropped responses can pile up across several redirects, so this is kept wide.
  localparam int unsigned DISCARD_W        = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer between the memory response path and decode.
// Pointers wrap modulo DEPTH; flush empties the buffer without touching storage.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           do_push_s;
  logic           do_pop_s;

  // Qualify the requests against occupancy and expose status.
  always_comb begin
    empty     = (count_r == '0);
    full      = (count_r == CW'(DEPTH));
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    head      = mem_r[rd_ptr_r];
    count     = count_r;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, response buffer, redirects.
// Optional FETCH_MISALIGN_CHECK_EN adds o_misaligned and blocks fetch after an unaligned redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        o_misaligned
`endif
);

  localparam int unsigned       CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]          pc_r;
  logic [CNT_W-1:0]     outstanding_r;
  logic [DISCARD_W-1:0] discard_r;

  logic [CNT_W-1:0]     fifo_count_s;
  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  fetch_entry_t         head_s;
  fetch_entry_t         push_entry_s;
  logic [CNT_W:0]       inflight_s;
  logic                 credit_ok_s;
  logic                 block_s;
  logic                 issue_s;
  logic                 rsp_keep_s;
  logic                 rsp_drop_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 flush_s;
  logic [31:0]          redirect_target_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_r;

  assign redirect_target_s = i_redirect_pc;
  assign block_s           = misaligned_r;
  assign o_misaligned      = misaligned_r;

  // Sticky flag: set by an unaligned redirect, cleared only by an aligned one.
  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned_r <= 1'b0;
    end else if (clk_en && i_redirect) begin
      misaligned_r <= (i_redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign redirect_target_s = i_redirect_pc & 32'hFFFF_FFFC;
  assign block_s           = 1'b0;
`endif

  // Credit check, handshake qualification and decode-facing outputs.
  always_comb begin
    inflight_s   = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
    credit_ok_s  = (inflight_s < DEPTH_C);
    o_imem_req   = ~rst & clk_en & ~i_redirect & ~block_s & credit_ok_s;
    o_imem_addr  = pc_r;
    issue_s      = o_imem_req & i_imem_gnt;
    rsp_drop_s   = clk_en & i_imem_rvalid & (discard_r != '0);
    rsp_keep_s   = clk_en & ~i_redirect & i_imem_rvalid & (discard_r == '0);
    push_s       = rsp_keep_s & ~fifo_full_s;
    o_valid      = ~fifo_empty_s & ~block_s;
    pop_s        = clk_en & ~i_redirect & o_valid & i_ready;
    flush_s      = clk_en & i_redirect;
    // The oldest live request sits 'outstanding' words behind the current pc.
    push_entry_s.instr = i_imem_rdata;
    push_entry_s.pc    = pc_r - (32'(outstanding_r) << 2);
    o_instruction = o_valid ? head_s.instr : 32'h0000_0000;
    o_pc          = o_valid ? head_s.pc    : 32'h0000_0000;
  end

  // PC, live-request and drop counters; a redirect overrides issue and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      outstanding_r <= '0;
      discard_r     <= '0;
    end else if (clk_en) begin
      if (i_redirect) begin
        pc_r          <= redirect_target_s;
        outstanding_r <= '0;
        discard_r     <= discard_r + DISCARD_W'(outstanding_r) - DISCARD_W'(i_imem_rvalid);
      end else begin
        if (issue_s) begin
          pc_r <= next_pc(pc_r);
        end
        outstanding_r <= outstanding_r + CNT_W'(issue_s) - CNT_W'(rsp_keep_s);
        discard_r     <= discard_r - DISCARD_W'(rsp_drop_s);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner cases, random traffic vs stream model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, clk_en, o_imem_req, i_imem_gnt, i_imem_rvalid, i_redirect, o_valid, i_ready;
  logic [31:0] o_imem_addr, i_imem_rdata, i_redirect_pc, o_instruction, o_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        o_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_instruction(o_instruction), .o_pc(o_pc), .o_valid(o_valid), .i_ready(i_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .o_misaligned(o_misaligned)
`endif
  );

  // drive intent for the next cycle
  logic        d_rst, d_en, d_gnt, d_rv_en, d_ready, d_redir;
  logic [31:0] d_rpc;
  // stream model: next pc to deliver, next pc to request, requests not yet consumed
  logic [31:0] m_exp_pc, m_issue;
  int          m_live;
  bit          m_after_redir, m_mis;
  logic [31:0] memq[$];
  logic [31:0] got_pcs[$];
  // samples
  logic        s_req, s_valid, s_rv;
  logic [31:0] s_addr, s_pc, s_instr;
  int n_checks = 0, n_pass = 0, cyc = 0, delivered = 0, n_grants = 0;
  int first_grant = -1, first_valid = -1;
  bit const_data = 1'b1;

  typedef struct {
    logic        rst, en, gnt, redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    logic [31:0] d;
    d = {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
    return const_data ? 32'h0000_0013 : d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    logic        e_req;
    logic [31:0] tgt;
    @(negedge clk);
    rst = d_rst; clk_en = d_en; i_imem_gnt = d_gnt; i_ready = d_ready;
    i_redirect = d_redir; i_redirect_pc = d_rpc;
    s_rv = d_en & ~d_rst & d_rv_en & (memq.size() > 0);
    i_imem_rvalid = s_rv;
    i_imem_rdata  = s_rv ? data_fn(memq[0]) : $urandom;
    #1;
    s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_valid; s_pc = o_pc; s_instr = o_instruction;
    e_req = ~d_rst & d_en & ~d_redir & ~m_mis & (m_live < DEPTH);
    check("req", 32'(s_req), 32'(e_req));
    if (!d_rst) begin
      check("addr", s_addr, m_issue);
      if (m_after_redir) check("valid_after_redirect", 32'(s_valid), 32'd0);
      if (s_valid) begin
        check("pc", s_pc, m_exp_pc);
        check("instr", s_instr, data_fn(m_exp_pc));
        check("valid_has_fetch", 32'(m_live > 0), 32'd1);
      end else begin
        check("gated_out", s_pc | s_instr, 32'd0);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      check("misaligned", 32'(o_misaligned), 32'(m_mis));
      if (m_mis) check("valid_while_misaligned", 32'(s_valid), 32'd0);
`endif
    end
    if (s_req && d_gnt && first_grant < 0) first_grant = cyc;
    if (s_valid && first_valid < 0) first_valid = cyc;
    @(posedge clk);
    if (d_rst) begin
      m_exp_pc = 32'd0; m_issue = 32'd0; m_live = 0; m_after_redir = 1'b0; m_mis = 1'b0;
      memq.delete();
    end else if (d_en) begin
      if (s_rv) void'(memq.pop_front());
      if (s_req && d_gnt) begin
        memq.push_back(s_addr);
        n_grants++;
      end
      if (d_redir) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        tgt   = d_rpc;
        m_mis = (d_rpc[1:0] != 2'b00);
`else
        tgt   = d_rpc & 32'hFFFF_FFFC;
`endif
        m_exp_pc = tgt; m_issue = tgt; m_live = 0; m_after_redir = 1'b1;
      end else begin
        if (e_req && d_gnt) begin
          m_live++;
          m_issue += 32'd4;
        end
        if (s_valid && d_ready) begin
          m_live--;
          got_pcs.push_back(s_pc);
          delivered++;
          m_exp_pc += 32'd4;
        end
        m_after_redir = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    d_rst = 1'b1; step(); d_rst = 1'b0;
    n_grants = 0; got_pcs.delete();
  endtask

  task automatic redirect_to(input logic [31:0] t);
    d_redir = 1'b1; d_rpc = t; step(); d_redir = 1'b0; got_pcs.delete(); n_grants = 0;
  endtask

  task automatic check_pc_at(input string name, input int idx, input logic [31:0] exp);
    if (got_pcs.size() > idx) check(name, got_pcs[idx], exp);
    else check({name, "_present"}, 32'(got_pcs.size()), 32'(idx + 1));
  endtask

  initial begin
    d_rst = 1'b1; d_en = 1'b1; d_gnt = 1'b0; d_rv_en = 1'b0; d_ready = 1'b0;
    d_redir = 1'b0; d_rpc = 32'd0;
    repeat (2) step();

    // reset dominance, stall and held-off grant
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0};
    for (int i = 4; i < 9; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      d_rst = vecs[i].rst; d_en = vecs[i].en; d_gnt = vecs[i].gnt;
      d_redir = vecs[i].redir; d_rpc = vecs[i].rpc;
      step();
      check("vec_req",   32'(s_req),   32'(vecs[i].exp_req));
      check("vec_addr",  s_addr,       vecs[i].exp_addr);
      check("vec_valid", 32'(s_valid), 32'(vecs[i].exp_valid));
    end
    d_redir = 1'b0; d_rst = 1'b0; d_en = 1'b1;

    // streaming with single-cycle memory
    d_gnt = 1'b1; d_rv_en = 1'b1; d_ready = 1'b1;
    first_grant = -1; first_valid = -1; delivered = 0; got_pcs.delete();
    repeat (12) step();
    check("first_latency", 32'(first_valid - first_grant), 32'd2);
    check("stream_throughput", 32'(delivered >= 5), 32'd1);
    check_pc_at("stream_pc0", 0, 32'h0);
    check_pc_at("stream_pc1", 1, 32'h4);
    check_pc_at("stream_pc2", 2, 32'h8);

    // decode backpressure fills the buffer, then drains in order
    do_reset();
    d_ready = 1'b0;
    repeat (10) step();
    check("bp_grants", 32'(n_grants), 32'd2);
    check("bp_req_low", 32'(s_req), 32'd0);
    check("bp_valid_held", 32'(s_valid), 32'd1);
    d_ready = 1'b1; got_pcs.delete();
    repeat (4) step();
    check_pc_at("bp_pc0", 0, 32'h0);
    check_pc_at("bp_pc1", 1, 32'h4);

    // global stall mid-stream
    d_en = 1'b0; n_grants = 0;
    repeat (3) step();
    check("stall_req", 32'(s_req), 32'd0);
    check("stall_grants", 32'(n_grants), 32'd0);
    d_en = 1'b1;
    repeat (6) step();

    // redirect with two requests in flight
    do_reset();
    d_rv_en = 1'b0;
    repeat (3) step();
    check("inflight_grants", 32'(n_grants), 32'd2);
    redirect_to(32'h0000_0100);
    d_rv_en = 1'b1;
    repeat (8) step();
    check_pc_at("redir_pc0", 0, 32'h100);
    check_pc_at("redir_pc1", 1, 32'h104);

    // back-to-back redirects: last one wins
    d_redir = 1'b1; d_rpc = 32'h300; step();
    redirect_to(32'h400);
    repeat (8) step();
    check_pc_at("b2b_pc0", 0, 32'h400);

    // pc wraps past the top of the address space
    redirect_to(32'hFFFF_FFF8);
    repeat (10) step();
    check_pc_at("wrap_pc2", 2, 32'h0);
    check_pc_at("wrap_pc3", 3, 32'h4);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect_to(32'h0000_0102);
    check("mis_set", 32'(o_misaligned), 32'd1);
    repeat (4) step();
    check("mis_no_grants", 32'(n_grants), 32'd0);
    redirect_to(32'h0000_0200);
    repeat (6) step();
    check_pc_at("mis_resume_pc0", 0, 32'h200);
`else
    redirect_to(32'h0000_0503);
    repeat (6) step();
    check_pc_at("lowbits_forced_pc0", 0, 32'h500);
`endif

    // random traffic against the stream model
    const_data = 1'b0;
    do_reset();
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      d_en    = ($urandom % 10) != 0;
      d_gnt   = ($urandom % 10) < 7;
      d_rv_en = ($urandom % 10) < 6;
      d_ready = ($urandom % 10) < 7;
      d_redir = ($urandom % 32) == 0;
      d_rpc   = $urandom;
      d_rst   = ($urandom % 500) == 0;
      step();
    end
    check("random_delivered", 32'(delivered > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
